// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with a one-entry skid buffer, so MEM ready never reaches ex_ready combinationally
`ifndef TYPE_I
`define TYPE_I 2'b00
`endif
module ex_mem_skid #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [DW-1:0]    ex_alu_result,
    input  logic [DW-1:0]    ex_store_data,
    input  logic             ex_mem_wr,
    input  logic             ex_reg_wr,
    input  logic [4:0]       ex_waddr,
    input  logic [1:0]       ex_instr_type,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [DW-1:0]    mem_alu_result,
    output logic [DW-1:0]    mem_store_data,
    output logic             mem_mem_wr,
    output logic             mem_reg_wr,
    output logic [4:0]       mem_waddr,
    output logic [1:0]       mem_instr_type,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic          mw;
        logic          rw;
        logic [4:0]    wa;
        logic [1:0]    it;
    } bundle_t;

    localparam bundle_t RST_B = '{alu: '0, sd: '0, mw: 1'b0, rw: 1'b0, wa: 5'd0, it: `TYPE_I};

    bundle_t main_b, skid_b, in_b;
    logic    main_valid, skid_valid, acc, out;

    assign in_b     = {ex_alu_result, ex_store_data, ex_mem_wr, ex_reg_wr, ex_waddr, ex_instr_type};
    assign ex_ready = rst & ~skid_valid;
    assign acc      = ex_valid & ex_ready;
    assign out      = main_valid & mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_b     <= RST_B;
            skid_b     <= RST_B;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (main_valid && !mem_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid) begin
                if (acc) begin
                    main_b     <= in_b;
                    main_valid <= 1'b1;
                end
            end else if (out) begin
                if (skid_valid) begin
                    main_b     <= skid_b;
                    skid_valid <= 1'b0;
                end else if (acc)
                    main_b <= in_b;
                else
                    main_valid <= 1'b0;
            end else if (acc) begin
                // skid can only be empty here, since a full skid holds ex_ready low
                skid_b     <= in_b;
                skid_valid <= 1'b1;
            end
        end
    end

    assign mem_valid      = main_valid;
    assign mem_alu_result = main_b.alu;
    assign mem_store_data = main_b.sd;
    assign mem_mem_wr     = main_b.mw & main_valid;
    assign mem_reg_wr     = main_b.rw & main_valid;
    assign mem_waddr      = main_b.wa;
    assign mem_instr_type = main_b.it;
endmodule
